// File: rtl/ddr3_app_pkg.sv
// Shared constants and state encoding for the DDR3 app-interface responder.
package ddr3_app_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam int APP_ADDR_W  = 27;
  localparam int APP_DATA_W  = 128;
  localparam int APP_BURST_W = 6;

  typedef enum logic [2:0] {
    ST_CALIB   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WR      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD      = 3'd4,
    ST_GAP     = 3'd5
  } app_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_app_responder_if.sv
// App-side command/write/read bundle; master is the tester, slave is the responder.
interface ddr3_app_responder_if;
  import ddr3_app_pkg::*;

  logic                   init_calib_complete;
  logic [APP_BURST_W-1:0] app_burst_number;
  logic [APP_ADDR_W-1:0]  app_addr;
  logic                   app_cmd_en;
  logic [2:0]             app_cmd;
  logic                   app_cmd_rdy;
  logic                   app_wdata_en;
  logic                   app_wdata_end;
  logic [APP_DATA_W-1:0]  app_wdata;
  logic                   app_wdata_rdy;
  logic                   app_rdata_valid;
  logic                   app_rdata_end;
  logic [APP_DATA_W-1:0]  app_rdata;

  modport master (
    input  init_calib_complete, app_cmd_rdy, app_wdata_rdy,
           app_rdata_valid, app_rdata_end, app_rdata,
    output app_burst_number, app_addr, app_cmd_en, app_cmd,
           app_wdata_en, app_wdata_end, app_wdata
  );

  modport slave (
    output init_calib_complete, app_cmd_rdy, app_wdata_rdy,
           app_rdata_valid, app_rdata_end, app_rdata,
    input  app_burst_number, app_addr, app_cmd_en, app_cmd,
           app_wdata_en, app_wdata_end, app_wdata
  );

endinterface

// File: rtl/app_resp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, 1-cycle read.
module app_resp_ram #(
  parameter int AW = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Write-first: a same-address read in the write cycle returns the new word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ddr3_app_responder.sv
// RAM-backed stand-in for the DDR3 controller's app interface.
//
// state      | meaning
// CALIB      | post-reset delay, no commands accepted
// IDLE       | command and write-data ready
// WR         | accepting write beats of the current burst
// RD_WAIT    | holding off so beat 0 lands RD_LAT cycles after acceptance
// RD         | RAM reads issuing / read beats streaming out
// GAP        | both ready outputs low for CMD_GAP cycles
module ddr3_app_responder
  import ddr3_app_pkg::*;
#(
  parameter int MEM_AW       = 10,
  parameter int CALIB_CYCLES = 256,
  parameter int RD_LAT       = 4,
  parameter int CMD_GAP      = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  ddr3_app_responder_if.slave  app,
  output logic                 err
);

  localparam int TMR_MAX = max_int(max_int(CALIB_CYCLES, RD_LAT), max_int(CMD_GAP, 1));
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = APP_BURST_W + 1;

  localparam logic [TMR_W-1:0] CALIB_LOAD = TMR_W'(CALIB_CYCLES - 1);
  localparam logic [TMR_W-1:0] RDW_LOAD   = TMR_W'(RD_LAT - 2);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'((CMD_GAP > 0) ? CMD_GAP - 1 : 0);
  localparam app_state_e       DONE_ST    = (CMD_GAP == 0) ? ST_IDLE : ST_GAP;

  app_state_e          state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [MEM_AW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                calib_q, calib_d;
  logic                err_q, err_d;
  logic                rd_vld_q, rd_vld_d;
  logic                rd_last_q, rd_last_d;
  logic                rdata_vld_q, rdata_vld_d;
  logic                rdata_end_q, rdata_end_d;
  logic [APP_DATA_W-1:0] rdata_q, rdata_d;

  logic [MEM_AW-1:0]     addr_base;
  logic [MEM_AW-1:0]     cur_ptr;
  logic [CNT_W-1:0]      cur_cnt;
  logic                  beat;
  logic                  cmd_rdy;
  logic                  wdata_rdy;
  logic                  ram_we;
  logic                  ram_re;
  logic [APP_DATA_W-1:0] ram_rdata;
  logic                  unused_addr_bits;

  assign addr_base        = app.app_addr[MEM_AW+2:3];
  assign unused_addr_bits = ^{app.app_addr[APP_ADDR_W-1:MEM_AW+3], app.app_addr[2:0]};

  app_resp_ram #(
    .AW (MEM_AW),
    .DW (APP_DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cur_ptr),
    .wdata (app.app_wdata),
    .re    (ram_re),
    .raddr (ptr_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_CALIB;
      tmr_q       <= CALIB_LOAD;
      ptr_q       <= '0;
      cnt_q       <= '0;
      calib_q     <= 1'b0;
      err_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rdata_vld_q <= 1'b0;
      rdata_end_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      calib_q     <= calib_d;
      err_q       <= err_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      rdata_vld_q <= rdata_vld_d;
      rdata_end_q <= rdata_end_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    calib_d   = calib_q;
    err_d     = err_q;
    cur_ptr   = ptr_q;
    cur_cnt   = cnt_q;
    beat      = 1'b0;
    cmd_rdy   = 1'b0;
    wdata_rdy = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;

    unique case (state_q)
      ST_CALIB: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
          calib_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_IDLE: begin
        cmd_rdy   = 1'b1;
        wdata_rdy = 1'b1;
        if (app.app_cmd_en) begin
          ptr_d = addr_base;
          cnt_d = {1'b0, app.app_burst_number} + CNT_W'(1);
          if (app.app_cmd == APP_CMD_WR) begin
            state_d = ST_WR;
            cur_ptr = addr_base;
            cur_cnt = {1'b0, app.app_burst_number} + CNT_W'(1);
            beat    = app.app_wdata_en;
          end else if (app.app_cmd == APP_CMD_RD) begin
            state_d = ST_RD_WAIT;
            tmr_d   = RDW_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
        // Write data with no write command alongside it has nowhere to go.
        if (app.app_wdata_en && !(app.app_cmd_en && (app.app_cmd == APP_CMD_WR))) begin
          err_d = 1'b1;
        end
      end
      ST_WR: begin
        wdata_rdy = 1'b1;
        beat      = app.app_wdata_en;
      end
      ST_RD_WAIT: begin
        if (tmr_q == '0) begin
          state_d = ST_RD;
          ram_re  = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_RD: begin
        ram_re = (cnt_q != '0);
        if (rdata_end_q) begin
          state_d = DONE_ST;
          tmr_d   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_CALIB;
        tmr_d   = CALIB_LOAD;
      end
    endcase

    if (beat) begin
      ram_we = 1'b1;
      ptr_d  = cur_ptr + MEM_AW'(1);
      cnt_d  = cur_cnt - CNT_W'(1);
      // Either the last counted beat or an early end closes the burst.
      if ((cur_cnt == CNT_W'(1)) || app.app_wdata_end) begin
        state_d = DONE_ST;
        tmr_d   = GAP_LOAD;
        if ((cur_cnt != CNT_W'(1)) || !app.app_wdata_end) err_d = 1'b1;
      end
    end

    if (ram_re) begin
      ptr_d = ptr_q + MEM_AW'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Two-stage read pipe: RAM output register, then the app_rdata register.
  always_comb begin
    rd_vld_d    = ram_re;
    rd_last_d   = ram_re && (cnt_q == CNT_W'(1));
    rdata_vld_d = rd_vld_q;
    rdata_end_d = rd_last_q;
    rdata_d     = rd_vld_q ? ram_rdata : rdata_q;
  end

  assign app.init_calib_complete = calib_q;
  assign app.app_cmd_rdy         = cmd_rdy;
  assign app.app_wdata_rdy       = wdata_rdy;
  assign app.app_rdata_valid     = rdata_vld_q;
  assign app.app_rdata_end       = rdata_end_q;
  assign app.app_rdata           = rdata_q;
  assign err                     = err_q;

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed self-checking bench for ddr3_app_responder with default parameters.
module tb_ddr3_app_responder;
  import ddr3_app_pkg::*;

  logic clk;
  logic rstn;
  logic err;

  int checks = 0;
  int errors = 0;

  logic [127:0] wr_data [0:63];
  logic [127:0] rd_q    [0:69];
  int rd_lat, rd_cnt, rd_end_idx, rd_end_cnt, calib_wait;

  ddr3_app_responder_if app_if ();

  ddr3_app_responder #(
    .MEM_AW       (10),
    .CALIB_CYCLES (256),
    .RD_LAT       (4),
    .CMD_GAP      (1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .app  (app_if),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle_inputs();
    app_if.app_cmd_en       = 1'b0;
    app_if.app_cmd          = 3'b000;
    app_if.app_addr         = '0;
    app_if.app_burst_number = '0;
    app_if.app_wdata_en     = 1'b0;
    app_if.app_wdata_end    = 1'b0;
    app_if.app_wdata        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_calib();
    calib_wait = 0;
    while (!app_if.init_calib_complete && calib_wait < 400) begin
      tick();
      calib_wait++;
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_calib();
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!app_if.app_cmd_rdy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic write_burst(input logic [26:0] addr, input int n, input int holes, input int end_at);
    wait_rdy();
    app_if.app_cmd_en       = 1'b1;
    app_if.app_cmd          = APP_CMD_WR;
    app_if.app_addr         = addr;
    app_if.app_burst_number = 6'(n);
    for (int k = 0; k <= n; k++) begin
      app_if.app_wdata_en  = 1'b1;
      app_if.app_wdata     = wr_data[k];
      app_if.app_wdata_end = (k == end_at);
      tick();
      app_if.app_cmd_en    = 1'b0;
      app_if.app_wdata_en  = 1'b0;
      app_if.app_wdata_end = 1'b0;
      if (k == end_at) break;
      repeat (holes) tick();
    end
  endtask

  task automatic issue_read(input logic [26:0] addr, input int n);
    wait_rdy();
    app_if.app_cmd_en       = 1'b1;
    app_if.app_cmd          = APP_CMD_RD;
    app_if.app_addr         = addr;
    app_if.app_burst_number = 6'(n);
    tick();
    app_if.app_cmd_en = 1'b0;
  endtask

  task automatic read_burst(input logic [26:0] addr, input int n);
    int i = 0;
    issue_read(addr, n);
    rd_lat = -1; rd_cnt = 0; rd_end_idx = -1; rd_end_cnt = 0;
    while (!app_if.app_rdata_valid && i < 20) begin
      tick();
      i++;
    end
    if (app_if.app_rdata_valid) rd_lat = i;
    while (app_if.app_rdata_valid && rd_cnt < 70) begin
      rd_q[rd_cnt] = app_if.app_rdata;
      if (app_if.app_rdata_end) begin
        rd_end_cnt++;
        if (rd_end_idx < 0) rd_end_idx = rd_cnt;
      end
      rd_cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n = 0;
    int bad = 0;
    idle_inputs();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({app_if.init_calib_complete, app_if.app_cmd_rdy, app_if.app_wdata_rdy,
         app_if.app_rdata_valid, app_if.app_rdata_end, err} !== 6'b0 || app_if.app_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: outputs not all zero during reset");
    end
    rstn = 1'b1;
    while (!app_if.init_calib_complete && n < 400) begin
      if (app_if.app_cmd_rdy || app_if.app_wdata_rdy || app_if.app_rdata_valid ||
          app_if.app_rdata_end || err || app_if.app_rdata !== '0) bad++;
      tick();
      n++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL precalib_outputs: %0d cycles with nonzero outputs, want 0", bad);
    end
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL calib_delay: got %0d cycles want 256", n);
    end
    checks++;
    if ({app_if.app_cmd_rdy, app_if.app_wdata_rdy} !== 2'b11) begin
      errors++;
      $display("FAIL rdy_after_calib: got %b want 11", {app_if.app_cmd_rdy, app_if.app_wdata_rdy});
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_after_calib: got %b want 0", err);
    end
  endtask

  task automatic test_single();
    wr_data[0] = {16{8'hA5}};
    write_burst(27'h000010, 0, 0, 0);
    read_burst(27'h000010, 0);
    checks++;
    if (rd_lat !== 4) begin errors++; $display("FAIL single_latency: got %0d want 4", rd_lat); end
    checks++;
    if (rd_cnt !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", rd_cnt); end
    checks++;
    if (rd_end_idx !== 0) begin errors++; $display("FAIL single_end: got %0d want 0", rd_end_idx); end
    checks++;
    if (rd_q[0] !== {16{8'hA5}}) begin errors++; $display("FAIL single_data: got %h want %h", rd_q[0], {16{8'hA5}}); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err); end
  endtask

  task automatic test_wrap();
    int bad = 0;
    for (int k = 0; k < 4; k++) wr_data[k] = 128'(k);
    write_burst(27'(1023 * 8), 3, 0, 3);
    read_burst(27'(1023 * 8), 3);
    for (int k = 0; k < 4; k++) if (rd_q[k] !== 128'(k)) bad++;
    checks++;
    if (rd_cnt !== 4 || bad !== 0 || rd_end_idx !== 3) begin
      errors++;
      $display("FAIL wrap_burst: count %0d mism %0d end %0d, want 4 0 3", rd_cnt, bad, rd_end_idx);
    end
    read_burst(27'h0, 0);
    checks++;
    if (rd_cnt !== 1 || rd_q[0] !== 128'd1) begin
      errors++;
      $display("FAIL wrap_index0: got %h (count %0d) want 1", rd_q[0], rd_cnt);
    end
    // bit 13 is above the RAM index and bits 2:0 are sub-beat, so this aliases index 1023
    read_burst(27'(1023 * 8) | 27'h2000 | 27'h5, 0);
    checks++;
    if (rd_cnt !== 1 || rd_q[0] !== 128'd0) begin
      errors++;
      $display("FAIL addr_alias: got %h (count %0d) want 0", rd_q[0], rd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int k = 0; k < 64; k++)
      wr_data[k] = {32'(k), 32'hDEADBEEF, ~32'(k), 32'(k * 3)};
    write_burst(27'(100 * 8), 63, 2, 63);
    checks++;
    if (app_if.app_cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL gap_rdy_low: got %b want 0", app_if.app_cmd_rdy);
    end
    tick();
    checks++;
    if (app_if.app_cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL gap_rdy_high: got %b want 1", app_if.app_cmd_rdy);
    end
    read_burst(27'(100 * 8), 63);
    for (int k = 0; k < 64; k++) if (rd_q[k] !== wr_data[k]) bad++;
    checks++;
    if (rd_lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", rd_lat); end
    checks++;
    if (rd_cnt !== 64) begin errors++; $display("FAIL b2b_count: got %0d want 64", rd_cnt); end
    checks++;
    if (rd_end_idx !== 63 || rd_end_cnt !== 1) begin
      errors++; $display("FAIL b2b_end: idx %0d count %0d want 63 1", rd_end_idx, rd_end_cnt);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_data: %0d mismatched beats want 0", bad); end
    checks++;
    if (app_if.app_rdata !== wr_data[63]) begin
      errors++; $display("FAIL rdata_hold: got %h want %h", app_if.app_rdata, wr_data[63]);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", err); end
  endtask

  task automatic test_reset_mid_read();
    int i = 0;
    int bad = 0;
    issue_read(27'(100 * 8), 31);
    while (!app_if.app_rdata_valid && i < 20) begin tick(); i++; end
    repeat (10) tick();
    checks++;
    if (app_if.app_rdata_valid !== 1'b1 || app_if.app_rdata !== wr_data[10]) begin
      errors++;
      $display("FAIL midread_beat10: valid %b data %h want 1 %h", app_if.app_rdata_valid, app_if.app_rdata, wr_data[10]);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({app_if.app_rdata_valid, app_if.app_rdata_end, app_if.app_cmd_rdy,
         app_if.init_calib_complete} !== 4'b0 || app_if.app_rdata !== '0) begin
      errors++;
      $display("FAIL midread_async_reset: valid %b end %b rdy %b calib %b want all 0",
               app_if.app_rdata_valid, app_if.app_rdata_end, app_if.app_cmd_rdy, app_if.init_calib_complete);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_calib();
    checks++;
    if (calib_wait !== 256) begin errors++; $display("FAIL recalib_delay: got %0d want 256", calib_wait); end
    read_burst(27'(100 * 8), 63);
    for (int k = 0; k < 64; k++) if (rd_q[k] !== wr_data[k]) bad++;
    checks++;
    if (rd_cnt !== 64 || bad !== 0) begin
      errors++; $display("FAIL ram_retained: count %0d mism %0d want 64 0", rd_cnt, bad);
    end
  endtask

  task automatic test_protocol_errors();
    int seen = 0;
    apply_reset();
    wr_data[0] = 128'h1111; wr_data[1] = 128'h2222;
    write_burst(27'(200 * 8), 3, 0, 1);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL early_end_err: got %b want 1", err); end
    tick();
    checks++;
    if (app_if.app_cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL early_end_idle: rdy %b want 1", app_if.app_cmd_rdy);
    end
    read_burst(27'(200 * 8), 1);
    checks++;
    if (rd_cnt !== 2 || rd_q[0] !== 128'h1111 || rd_q[1] !== 128'h2222) begin
      errors++; $display("FAIL early_end_data: count %0d d0 %h d1 %h want 2 1111 2222", rd_cnt, rd_q[0], rd_q[1]);
    end

    apply_reset();
    app_if.app_cmd_en = 1'b1; app_if.app_cmd = 3'b101; app_if.app_addr = 27'(200 * 8);
    app_if.app_burst_number = '0;
    tick();
    app_if.app_cmd_en = 1'b0;
    checks++;
    if (err !== 1'b1 || app_if.app_cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL illegal_cmd: err %b rdy %b want 1 1", err, app_if.app_cmd_rdy);
    end
    repeat (8) begin tick(); if (app_if.app_rdata_valid) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL illegal_cmd_noread: %0d valid beats want 0", seen); end

    apply_reset();
    app_if.app_wdata_en = 1'b1; app_if.app_wdata = 128'hBAD;
    tick();
    app_if.app_wdata_en = 1'b0;
    checks++;
    if (err !== 1'b1 || app_if.app_cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL stray_wdata: err %b rdy %b want 1 1", err, app_if.app_cmd_rdy);
    end

    apply_reset();
    wr_data[0] = 128'h3333; wr_data[1] = 128'h4444;
    write_burst(27'(400 * 8), 1, 1, -1);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL missing_end_err: got %b want 1", err); end
    read_burst(27'(400 * 8), 1);
    checks++;
    if (rd_cnt !== 2 || rd_q[0] !== 128'h3333 || rd_q[1] !== 128'h4444) begin
      errors++; $display("FAIL missing_end_data: count %0d d0 %h d1 %h want 2 3333 4444", rd_cnt, rd_q[0], rd_q[1]);
    end
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_reset_mid_read();
    test_protocol_errors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_app_responder.md
Name: ddr3_app_responder

Overview:
- Synthesizable stand-in for the DDR3 controller's user (app) interface: the responder end that the bare tester drives as initiator.
- Backs a 128-bit-wide on-chip RAM so tester logic can be brought up in simulation and on fabric without the DDR3 PHY.
- Drops into the top level in place of the controller's app-side ports. The tester's clk_x1 connects to this block's clk.

Parameters:
MEM_AW, 10, log2 of RAM depth in 128-bit beats (1024 beats = 16 KiB)
CALIB_CYCLES, 256, cycles after reset release before init_calib_complete rises (>=1)
RD_LAT, 4, cycles from read-command acceptance to first app_rdata_valid (>=2)
CMD_GAP, 1, idle cycles app_cmd_rdy stays low after each burst completes (>=0)

Ports:
clk  input  1  app clock, all logic rising-edge
rstn  input  1  asynchronous active-low reset
init_calib_complete  output  1  high once the calibration delay has elapsed; stays high until reset
app_burst_number  input  6  burst length minus 1 (N+1 beats), sampled with the command
app_addr  input  27  column address in 16-bit units; one beat = 8 columns
app_cmd_en  input  1  command valid
app_cmd  input  3  3'b000 write, 3'b001 read, others illegal
app_cmd_rdy  output  1  command accepted when app_cmd_en and app_cmd_rdy are both high
app_wdata_en  input  1  write beat valid
app_wdata_end  input  1  marks last write beat
app_wdata  input  128  write beat data
app_wdata_rdy  output  1  beat accepted when app_wdata_en and app_wdata_rdy are both high
app_rdata_valid  output  1  read beat valid, no backpressure
app_rdata_end  output  1  high with the last read beat
app_rdata  output  128  read beat data
err  output  1  sticky protocol-error flag, cleared only by reset

Behaviour:
- Reset values: init_calib_complete=0, app_cmd_rdy=0, app_wdata_rdy=0, app_rdata_valid=0, app_rdata_end=0, app_rdata=0, err=0. RAM contents are not reset.
- States: CALIB, IDLE, WR, RD_WAIT, RD, GAP.
- CALIB:
  - A counter runs CALIB_CYCLES cycles after rstn deasserts, then the block goes to IDLE.
  - init_calib_complete is registered and rises on IDLE entry.
- IDLE:
  - app_cmd_rdy=1 and app_wdata_rdy=1.
  - On acceptance, latch beat index base = app_addr[MEM_AW+2:3] (addr[2:0] ignored), and latch count = app_burst_number.
  - Write command -> WR. Read command -> RD_WAIT. Illegal code -> set err, stay in IDLE.
  - A write beat in the same cycle as a write-command acceptance counts as beat 0.
  - A write beat in IDLE without a write command is dropped and sets err.
- WR:
  - app_cmd_rdy=0, app_wdata_rdy=1.
  - Each accepted beat writes RAM[(base+k) mod 2^MEM_AW] for k = 0..N.
  - Leave after beat N is written, -> GAP.
  - If app_wdata_end arrives with k<N, terminate early and set err.
  - If beat N arrives without app_wdata_end, complete the burst anyway and set err.
  - Gaps in app_wdata_en are legal.
- RD_WAIT:
  - Wait so that the first beat appears exactly RD_LAT cycles after the acceptance edge.
  - Issue the RAM read early enough to cover the 1-cycle synchronous RAM latency.
- RD:
  - Emit N+1 beats on consecutive cycles: app_rdata_valid=1, app_rdata = RAM[(base+k) mod depth].
  - app_rdata_end=1 only with beat N. Then -> GAP.
  - app_rdata holds its last value when valid is low.
- GAP: CMD_GAP cycles with both rdy outputs low, then -> IDLE. With CMD_GAP=0, go straight to IDLE.
- Address wrap: a burst crossing the top of the RAM wraps to index 0. app_addr bits above MEM_AW+2 are ignored (aliasing).
- Read-after-write: a read issued on the cycle after a write burst's last beat returns the new data. The RAM is write-first, or the read is issued no earlier than the cycle after the write.
- Commands before init_calib_complete: never accepted (rdy=0). A held app_cmd_en is not an error.
- rstn asserting mid-burst: immediate return to CALIB with all outputs at reset values. A partial write leaves RAM partially updated.

Decomposition:
- Shared package ddr3_app_pkg:
  - APP_CMD_WR=3'b000, APP_CMD_RD=3'b001
  - APP_ADDR_W=27, APP_DATA_W=128, APP_BURST_W=6
  - state enum for this block
- One sub-module: app_resp_ram, a simple dual-port synchronous RAM (1 write port, 1 read port, 1-cycle read, write-first), parameterized by MEM_AW and data width.

Test Plan:
- Reset and calibration: release rstn with CALIB_CYCLES=256 -> init_calib_complete and app_cmd_rdy rise exactly 256 cycles later; all outputs 0 before that.
- Single-beat write/read: write addr 0x000010, N=0, data 0xA5..A5, then read the same addr -> app_rdata_valid exactly 4 cycles after read acceptance (RD_LAT=4), with app_rdata_end=1 and data 0xA5..A5.
- Burst of 4 with wrap: write addr=(1023*8), N=3, data 0..3 -> read back from index 1023 returns 0,1,2,3. Reading index 0 alone returns 1.
- Burst of 64 back-to-back: write N=63 with incrementing data and 2-cycle wdata_en holes, then read N=63 -> 64 contiguous valid beats matching the written data, end on beat 63, err=0.
- Protocol errors: wdata_end on beat 1 of an N=3 write -> err=1, block returns to IDLE. Separately, app_cmd=3'b101 -> err=1 and the command is not executed.
- Reset mid-read: assert rstn during beat 10 of an N=31 read -> app_rdata_valid=0 immediately. After recalibration, previously written data reads back intact.
